// File: rtl/mem_access_sequencer.sv
// Memory-access sequencer: drives MAR/MDR loads and the MOV/MOC four-phase
// handshake for LW/SW, stalls the core while busy and flags memory timeouts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start from the decoder
// LOAD_MAR | load MAR with the ALU address
// LOAD_MDR | write only: load MDR from the register file
// REQ      | MOV high, waiting for MOC (timed)
// CAPTURE  | read only: latch memory bus into MDR, MOV still high
// RELEASE  | MOV low, waiting for MOC to drop (timed)
// DONE     | one-cycle completion pulse
// ERR      | sticky timeout, held until clear_err
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic rw_in,
  input  logic MOC,
  input  logic clear_err,
  output logic MAREnable,
  output logic MDREnable,
  output logic mdr_src,
  output logic MOV,
  output logic RW,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    IDLE, LOAD_MAR, LOAD_MDR, REQ, CAPTURE, RELEASE, DONE, ERR
  } state_t;

  state_t           state, state_nxt;
  logic             rw_q;
  logic [CNT_W-1:0] cnt;
  logic             tmo;

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rw_q  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start)
        rw_q <= rw_in;
      // Restart the timer on every entry into a timed wait state.
      if ((state_nxt == REQ && state != REQ) ||
          (state_nxt == RELEASE && state != RELEASE))
        cnt <= '0;
      else if (state == REQ || state == RELEASE)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LOAD_MAR;
      LOAD_MAR: state_nxt = rw_q ? REQ : LOAD_MDR;
      LOAD_MDR: state_nxt = REQ;
      REQ: begin
        // Completion beats a timeout landing in the same cycle.
        if (MOC)      state_nxt = rw_q ? CAPTURE : RELEASE;
        else if (tmo) state_nxt = ERR;
      end
      CAPTURE:  state_nxt = RELEASE;
      RELEASE: begin
        if (!MOC)     state_nxt = DONE;
        else if (tmo) state_nxt = ERR;
      end
      DONE:     state_nxt = IDLE;
      ERR:      if (clear_err) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MAREnable = 1'b0;
    MDREnable = 1'b0;
    mdr_src   = 1'b0;
    MOV       = 1'b0;
    RW        = rw_q;
    busy      = (state != IDLE);
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      LOAD_MAR: MAREnable = 1'b1;
      LOAD_MDR: MDREnable = 1'b1;
      REQ:      MOV = 1'b1;
      CAPTURE: begin
        MOV       = 1'b1;
        MDREnable = 1'b1;
        mdr_src   = 1'b1;
      end
      DONE:     done  = 1'b1;
      ERR:      error = 1'b1;
      default:  ;
    endcase
  end

endmodule
